// File: rtl/mem_multi_port.sv
// mem_multi_port: one word-addressed storage array shared by NUM_PORTS
// requestors through a round-robin arbiter. Supports per-byte write enables
// and a LATENCY-deep read pipeline that is tagged with the port index.
// Optional feature macro: MEM_MULTI_PORT_STALL_CNT_EN adds saturating
// per-port stall counters on stall_cnt_o.
module mem_multi_port #(
  parameter int NUM_PORTS  = 2,
  parameter int NUM_WORDS  = 64,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int LATENCY    = 1,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS),
  parameter int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PORTS-1:0]            req_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  input  logic [NUM_PORTS-1:0]            w_en_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] w_data_i,
  input  logic [NUM_PORTS*NUM_BYTES-1:0]  b_en_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] r_data_o,
  output logic [NUM_PORTS-1:0]            r_valid_o
`ifdef MEM_MULTI_PORT_STALL_CNT_EN
  ,
  output logic [NUM_PORTS*16-1:0]         stall_cnt_o
`endif
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  any_gnt;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_wen;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_BYTES-1:0]  sel_ben;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [LATENCY-1:0]    pipe_valid;
  logic [PTR_W-1:0]      pipe_port [LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_hold;

  // Round-robin search starting at rr_ptr; grants are suppressed during reset.
  always_comb begin
    int idx;
    gnt_o   = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    if (rst_ni) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!any_gnt && req_i[idx]) begin
          any_gnt      = 1'b1;
          gnt_idx      = PTR_W'(idx);
          gnt_o[idx]   = 1'b1;
        end
      end
    end
  end

  assign sel_addr = addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wen  = w_en_i[gnt_idx];
  assign sel_data = w_data_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_ben  = b_en_i[int'(gnt_idx)*NUM_BYTES +: NUM_BYTES];
  assign in_range = (int'(sel_addr) < NUM_WORDS);
  assign rd_word  = in_range ? mem[sel_addr] : '0;

  // Pointer moves just past the winner so the next search starts there.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (any_gnt) begin
      rr_ptr <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // Byte-lane merge write; array contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (any_gnt && sel_wen && in_range) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (sel_ben[b]) mem[sel_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= sel_data[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Read pipeline: stage 0 samples the array at the grant edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= any_gnt && !sel_wen;
      pipe_port[0]  <= gnt_idx;
      pipe_data[0]  <= rd_word;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_port[s]  <= pipe_port[s-1];
        pipe_data[s]  <= pipe_data[s-1];
      end
    end
  end

  // Per-port holding register keeps the last completed read visible.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_hold <= '0;
    end else if (pipe_valid[LATENCY-1]) begin
      r_hold[int'(pipe_port[LATENCY-1])*DATA_WIDTH +: DATA_WIDTH] <= pipe_data[LATENCY-1];
    end
  end

  // Completing read bypasses the holding register so data and valid coincide.
  always_comb begin
    r_valid_o = '0;
    r_data_o  = r_hold;
    if (pipe_valid[LATENCY-1]) begin
      r_valid_o[pipe_port[LATENCY-1]] = 1'b1;
      r_data_o[int'(pipe_port[LATENCY-1])*DATA_WIDTH +: DATA_WIDTH] = pipe_data[LATENCY-1];
    end
  end

`ifdef MEM_MULTI_PORT_STALL_CNT_EN
  logic [15:0] stall_cnt [NUM_PORTS];

  // Count cycles a port requested but lost arbitration, saturating.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int p = 0; p < NUM_PORTS; p++) stall_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (req_i[p] && !gnt_o[p] && stall_cnt[p] != 16'hFFFF) stall_cnt[p] <= stall_cnt[p] + 16'd1;
      end
    end
  end

  // Flatten counters onto the packed output.
  always_comb begin
    stall_cnt_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) stall_cnt_o[p*16 +: 16] = stall_cnt[p];
  end
`endif

endmodule

// File: tb/tb_mem_multi_port.sv
// Bench for mem_multi_port (2 ports, 64 x 32-bit, read latency 3).
// A reference model tracks memory contents, round-robin grants and pending
// reads, and is compared against the DUT on every falling edge.
module tb_mem_multi_port;
  localparam int NP  = 2;
  localparam int NW  = 64;
  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int NB  = 4;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NP-1:0]     req = '0;
  logic [NP-1:0]     gnt;
  logic [NP-1:0]     w_en = '0;
  logic [NP*AW-1:0]  addr = '0;
  logic [NP*DW-1:0]  w_data = '0;
  logic [NP*NB-1:0]  b_en = '0;
  logic [NP*DW-1:0]  r_data;
  logic [NP-1:0]     r_valid;
`ifdef MEM_MULTI_PORT_STALL_CNT_EN
  logic [NP*16-1:0]  stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mem_multi_port #(.NUM_PORTS(NP), .NUM_WORDS(NW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt), .w_en_i(w_en),
    .addr_i(addr), .w_data_i(w_data), .b_en_i(b_en), .r_data_o(r_data), .r_valid_o(r_valid)
`ifdef MEM_MULTI_PORT_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int port; logic [DW-1:0] data; } rd_t;
  rd_t           pend[$];
  logic [DW-1:0] mem_m [NW];
  logic [DW-1:0] hold_m [NP];
  int            stall_m [NP];
  int            rr_m = 0;
  int            cyc = 0;
  bit            armed = 0;

  always @(negedge clk) begin
    logic [NP-1:0] exp_v, exp_g;
    int gp, a;
    cyc++;
    exp_v = '0;
    exp_g = '0;
    gp = 0;
    if (armed) begin
      while (pend.size() > 0 && pend[0].due == cyc) begin
        exp_v[pend[0].port] = 1'b1;
        hold_m[pend[0].port] = pend[0].data;
        void'(pend.pop_front());
      end
      chk("r_valid", 64'(r_valid), 64'(exp_v));
      for (int p = 0; p < NP; p++) chk($sformatf("r_data[%0d]", p), 64'(r_data[p*DW +: DW]), 64'(hold_m[p]));
`ifdef MEM_MULTI_PORT_STALL_CNT_EN
      for (int p = 0; p < NP; p++) chk($sformatf("stall_cnt[%0d]", p), 64'(stall_cnt[p*16 +: 16]), 64'(stall_m[p]));
`endif
    end
    if (rst_ni) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (rr_m + k) % NP;
        if (exp_g == '0 && req[p]) begin
          exp_g[p] = 1'b1;
          gp = p;
        end
      end
    end
    if (armed) chk("gnt", 64'(gnt), 64'(exp_g));
    if (!rst_ni) begin
      armed = 1;
      rr_m = 0;
      pend.delete();
      for (int p = 0; p < NP; p++) begin hold_m[p] = '0; stall_m[p] = 0; end
    end else begin
      for (int p = 0; p < NP; p++)
        if (req[p] && !exp_g[p] && stall_m[p] < 65535) stall_m[p]++;
      if (exp_g != '0) begin
        rr_m = (gp + 1) % NP;
        a = int'(addr[gp*AW +: AW]);
        if (w_en[gp]) begin
          for (int b = 0; b < NB; b++)
            if (b_en[gp*NB + b]) mem_m[a][b*8 +: 8] = w_data[gp*DW + b*8 +: 8];
        end else begin
          pend.push_back('{due: cyc + LAT, port: gp, data: mem_m[a]});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the edge following the grant.
  task automatic access(input int p, input logic we, input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    int n;
    req[p] = 1'b1;
    w_en[p] = we;
    addr[p*AW +: AW] = AW'(a);
    w_data[p*DW +: DW] = d;
    b_en[p*NB +: NB] = be;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt[p] && n < 50);
    if (!gnt[p]) begin
      checks++; errors++;
      $display("FAIL grant_timeout: port %0d got no grant, expected one within 50 cycles", p);
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic wait_valid(input int p, output logic [DW-1:0] d);
    int n;
    n = 0;
    d = '0;
    do begin @(negedge clk); n++; end while (!r_valid[p] && n < 20);
    checks++;
    if (!r_valid[p]) begin
      errors++;
      $display("FAIL valid_timeout: port %0d no r_valid, expected within 20 cycles", p);
    end
    d = r_data[p*DW +: DW];
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst_ni = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] d, d0, d1;
    int c0, c1, vcnt, t0, t1;
    logic [DW-1:0] gold [NW];

    @(posedge clk); #1;
    do_reset(2);
    chk("reset_r_data", 64'(r_data), 64'h0);
    chk("reset_r_valid", 64'(r_valid), 64'h0);

    // write/read sweep on port 0
    for (int i = 0; i < NW; i++) begin
      gold[i] = $urandom;
      access(0, 1'b1, i, gold[i], 4'hF);
    end
    chk("r_data_before_first_read", 64'(r_data[0 +: DW]), 64'h0);
    for (int i = 0; i < NW; i++) access(0, 1'b0, i, '0, 4'h0);
    repeat (LAT + 1) @(posedge clk);
    #1;

    // byte-enable merge
    access(0, 1'b1, 5, 32'hAABBCCDD, 4'hF);
    access(0, 1'b1, 5, 32'h11223344, 4'b0101);
    access(0, 1'b0, 5, '0, 4'hF);
    wait_valid(0, d);
    chk("byte_merge", 64'(d), 64'hAA22CC44);

    // round-robin contention from reset
    do_reset(2);
    req = 2'b11; w_en = 2'b00;
    addr[0 +: AW] = 6'd3; addr[AW +: AW] = 6'd4;
    @(negedge clk);
    chk("contend_first_gnt", 64'(gnt), 64'b01);
    @(posedge clk); #1 req[0] = 1'b0;
    @(negedge clk);
    chk("contend_second_gnt", 64'(gnt), 64'b10);
    @(posedge clk); #1 req = '0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("contend_port0_data", 64'(r_data[0 +: DW]), 64'(gold[3]));
    chk("contend_port1_data", 64'(r_data[DW +: DW]), 64'(gold[4]));

    // fairness under continuous load
    do_reset(1);
    c0 = 0; c1 = 0;
    req = 2'b11; w_en = 2'b00;
    addr[0 +: AW] = 6'd10; addr[AW +: AW] = 6'd11;
    repeat (4 * NP) begin
      @(negedge clk);
      c0 += int'(gnt[0]);
      c1 += int'(gnt[1]);
    end
    @(posedge clk); #1 req = '0;
    chk("fair_port0_grants", 64'(c0), 64'd4);
    chk("fair_port1_grants", 64'(c1), 64'd4);
`ifdef MEM_MULTI_PORT_STALL_CNT_EN
    @(negedge clk);
    chk("fair_stall0_literal", 64'(stall_cnt[0 +: 16]), 64'd4);
    chk("fair_stall1_literal", 64'(stall_cnt[16 +: 16]), 64'd4);
    @(posedge clk); #1;
`endif
    repeat (LAT + 2) @(posedge clk);
    #1;

    // read-after-write and back-to-back pipelined reads
    access(0, 1'b1, 7, 32'h0000BEEF, 4'hF);
    access(0, 1'b0, 7, '0, 4'h0);
    access(0, 1'b0, 8, '0, 4'h0);
    vcnt = 0; t0 = 0; t1 = 0; d0 = '0; d1 = '0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (r_valid[0]) begin
        if (vcnt == 0) begin d0 = r_data[0 +: DW]; t0 = n; end
        else begin d1 = r_data[0 +: DW]; t1 = n; end
        vcnt++;
      end
    end
    @(posedge clk); #1;
    chk("raw_pulse_count", 64'(vcnt), 64'd2);
    chk("raw_first_data", 64'(d0), 64'h0000BEEF);
    chk("raw_second_data", 64'(d1), 64'(gold[8]));
    chk("raw_consecutive", 64'(t1 - t0), 64'd1);

    // reset while a read is in flight
    access(0, 1'b1, 9, 32'h12345678, 4'hF);
    req[0] = 1'b1; w_en[0] = 1'b0; addr[0 +: AW] = 6'd9;
    @(negedge clk);
    chk("midreset_read_gnt", 64'(gnt), 64'b01);
    @(posedge clk); #1;
    req = '0;
    rst_ni = 1'b0;
    @(posedge clk); #1 rst_ni = 1'b1;
    vcnt = 0;
    for (int n = 0; n < LAT + 3; n++) begin
      @(negedge clk);
      vcnt += int'(r_valid != '0);
    end
    chk("midreset_no_valid", 64'(vcnt), 64'd0);
    chk("midreset_r_data", 64'(r_data), 64'h0);
    @(posedge clk); #1;
    req = 2'b11; w_en = 2'b00;
    addr[0 +: AW] = 6'd9; addr[AW +: AW] = 6'd9;
    @(negedge clk);
    chk("midreset_ptr_zero", 64'(gnt), 64'b01);
    @(posedge clk); #1 req[0] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 req = '0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("midreset_persist_p0", 64'(r_data[0 +: DW]), 64'h12345678);
    chk("midreset_persist_p1", 64'(r_data[DW +: DW]), 64'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, expected completion");
    $fatal(1);
  end

endmodule
